// File: rtl/sd_pkg.sv
// Shared constants for the second-order sigma-delta modulator: input clamp window,
// mid-scale code, feedback magnitude and the integrator sum-width rule.
package sd_pkg;

  localparam logic [15:0] SD_MID      = 16'h8000;
  localparam logic [15:0] SD_CLAMP_LO = 16'h1000;
  localparam logic [15:0] SD_CLAMP_HI = 16'hF000;
  localparam int          SD_FB_MAG   = 32768;

  // Two guard bits hold acc + (|u| + |fb|) or acc + acc' + |fb| without wrapping,
  // so the result can be compared against the rails before truncation.
  function automatic int sd_sum_width(input int acc_w);
    return acc_w + 2;
  endfunction

endpackage

// File: rtl/sd_clk_gen.sv
// Bit/frame timebase: ph divides clk by DIV into mclk_out, bc counts OSR steps per frame.
// step/frame strobes are combinational and mark the edge they act on; no backpressure.
module sd_clk_gen #(
  parameter int DIV = 4,
  parameter int OSR = 256
) (
  input  logic clk,
  input  logic rst_n,
  output logic step,
  output logic frame,
  output logic mclk_out,
  output logic word_tick
);

  localparam int PW = $clog2(DIV);
  localparam int BW = $clog2(OSR);

  logic [PW-1:0] ph;
  logic [BW-1:0] bc;

  // Counters reset to their last value so the first edge after release is a frame start.
  assign step  = (ph == PW'(DIV - 1));
  assign frame = step && (bc == BW'(OSR - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph        <= PW'(DIV - 1);
      bc        <= BW'(OSR - 1);
      mclk_out  <= 1'b0;
      word_tick <= 1'b0;
    end else begin
      word_tick <= frame;
      if (step) begin
        ph       <= '0;
        mclk_out <= 1'b1;
        bc       <= (bc == BW'(OSR - 1)) ? '0 : bc + 1'b1;
      end else begin
        ph <= ph + 1'b1;
        if (ph == PW'(DIV / 2 - 1)) mclk_out <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/sd_modulator2.sv
// Second-order 1-bit sigma-delta modulator; a sample accepted now drives the loop from the
// next frame start. One-entry hold register: s_ready drops after accept until that frame start.
module sd_modulator2
  import sd_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int DIV       = 4,
  parameter int OSR       = 256,
  parameter int ACC_WIDTH = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic             mclk_out,
  output logic             mdata_out,
  output logic             word_tick,
  output logic             underrun
);

  localparam int SW = sd_sum_width(ACC_WIDTH);
  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
  localparam logic signed [WIDTH:0]       FB_POS  = (WIDTH+1)'(SD_FB_MAG);
  localparam logic signed [WIDTH:0]       FB_NEG  = -FB_POS;
  localparam logic signed [WIDTH:0]       U_MID   = $signed({1'b0, WIDTH'(SD_MID)});

  logic                        step;
  logic                        frame;
  logic                        accept;
  logic [WIDTH-1:0]            hold_dat;
  logic                        hold_full;
  logic                        primed;
  logic [WIDTH-1:0]            cur_dat;
  logic [WIDTH-1:0]            x_sel;
  logic [WIDTH-1:0]            x_clamp;
  logic signed [WIDTH:0]       u;
  logic signed [WIDTH:0]       fb;
  logic                        fb_bit;
  logic signed [SW-1:0]        s1;
  logic signed [SW-1:0]        s2;
  logic signed [ACC_WIDTH-1:0] i1;
  logic signed [ACC_WIDTH-1:0] i2;
  logic signed [ACC_WIDTH-1:0] i1_nxt;
  logic signed [ACC_WIDTH-1:0] i2_nxt;

  sd_clk_gen #(
    .DIV (DIV),
    .OSR (OSR)
  ) u_clk_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .step      (step),
    .frame     (frame),
    .mclk_out  (mclk_out),
    .word_tick (word_tick)
  );

  assign s_ready = !hold_full;
  assign accept  = s_valid && s_ready;

  // The step on a consuming frame start already runs on the new sample, so every
  // bit of a frame belongs to exactly one sample.
  always_comb begin
    x_sel = (frame && hold_full) ? hold_dat : cur_dat;
    if (x_sel < WIDTH'(SD_CLAMP_LO))      x_clamp = WIDTH'(SD_CLAMP_LO);
    else if (x_sel > WIDTH'(SD_CLAMP_HI)) x_clamp = WIDTH'(SD_CLAMP_HI);
    else                                  x_clamp = x_sel;
    u      = $signed({1'b0, x_clamp}) - U_MID;
    fb_bit = !i2[ACC_WIDTH-1];
    fb     = fb_bit ? FB_POS : FB_NEG;

    s1 = SW'(i1) + SW'(u) - SW'(fb);
    if (s1 > SW'(ACC_MAX))      i1_nxt = ACC_MAX;
    else if (s1 < SW'(ACC_MIN)) i1_nxt = ACC_MIN;
    else                        i1_nxt = s1[ACC_WIDTH-1:0];

    s2 = SW'(i2) + SW'(i1_nxt) - SW'(fb);
    if (s2 > SW'(ACC_MAX))      i2_nxt = ACC_MAX;
    else if (s2 < SW'(ACC_MIN)) i2_nxt = ACC_MIN;
    else                        i2_nxt = s2[ACC_WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_dat  <= '0;
      hold_full <= 1'b0;
      primed    <= 1'b0;
      cur_dat   <= WIDTH'(SD_MID);
      i1        <= '0;
      i2        <= '0;
      mdata_out <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      underrun <= 1'b0;
      if (step) begin
        i1        <= i1_nxt;
        i2        <= i2_nxt;
        mdata_out <= fb_bit;
      end
      if (frame) begin
        if (hold_full) cur_dat  <= hold_dat;
        else           underrun <= primed;
      end
      // accept needs an empty hold, so it never collides with a consuming frame start
      if (accept) begin
        hold_dat  <= s_data;
        hold_full <= 1'b1;
        primed    <= 1'b1;
      end else if (frame) begin
        hold_full <= 1'b0;
      end
    end
  end

endmodule

// File: doc/sd_modulator2.md
# sd_modulator2

Second-order digital sigma-delta modulator: the transmit-side counterpart of the sinc3 decimation filter. It accepts 16-bit unsigned PCM samples over a valid/ready handshake and emits a 1-bit density-modulated stream (`mdata_out`) with its own bit clock (`mclk_out`). It also emits a per-sample frame tick that can drive the filter's word clock. It sits in front of a 1-bit DAC/output buffer, or in a digital loopback with the sinc3 filter for self-test.

## Interface
- `WIDTH`, 16, sample width; input code is unsigned, 0 = negative full scale, mid-scale 0x8000.
- `DIV`, 4, `clk` cycles per modulator bit; even, ≥2.
- `OSR`, 256, modulator bits per sample (decimation rate of the matching filter).
- `ACC_WIDTH`, 20, signed integrator width; integrators saturate.

Ports:
- `clk`  in  1  single system clock; all logic on posedge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `s_data`  in  WIDTH  sample input, unsigned.
- `s_valid`  in  1  sample valid.
- `s_ready`  out  1  holding register empty; transfer when `s_valid & s_ready` on a `clk` edge.
- `mclk_out`  out  1  modulator bit clock, `clk`/DIV, 50% duty, registered.
- `mdata_out`  out  1  modulator bitstream; changes only with `mclk_out` rising, stable at its falling edge.
- `word_tick`  out  1  one-`clk` pulse at the start of each sample frame.
- `underrun`  out  1  one-`clk` pulse: frame started with holding register empty, after first sample ever accepted.

## Operation
- Reset values:
  - `mclk_out`=0, `mdata_out`=0, `word_tick`=0, `underrun`=0.
  - `s_ready`=1 (hold empty).
  - Current sample = 0x8000; integrators i1 = i2 = 0; primed flag = 0.
  - Phase counter ph = DIV-1; bit counter bc = OSR-1.
- Phase counter ph counts 0..DIV-1 every `clk`.
- Step edge: the edge where ph wraps DIV-1→0.
  - `mclk_out`<=1.
  - One modulator step executes.
  - bc advances (OSR-1→0 wrap).
- On the edge where ph becomes DIV/2, `mclk_out`<=0.
- Frame start: a step edge where bc wraps to 0.
  - `word_tick`=1 for that cycle.
  - If hold is full: current sample <= hold, hold empties.
  - If hold is empty: current sample is kept, and `underrun` pulses if primed.
- Hold register:
  - One entry; `s_ready` = !full.
  - An accept sets full and sets primed.
  - An accept on a frame-start edge with hold empty lands in hold. It does not take effect until the next frame. `underrun` still pulses.
- Input conditioning: x is clamped to [0x1000, 0xF000]; then u = x − 0x8000 (signed 17-bit).
- Modulator step, using pre-step registered values:
  - bit = (i2 ≥ 0).
  - fb = bit ? +32768 : −32768.
  - i1' = sat(i1 + u − fb).
  - i2' = sat(i2 + i1' − fb).
  - `mdata_out` <= bit.
- Saturation clamps to ±(2^(ACC_WIDTH−1)−1)/−2^(ACC_WIDTH−1). It never wraps.
- Ones density per frame ≈ (1 + u/32768)/2 × OSR.

## Timing
- First `clk` edge after reset deassertion is a step edge and a frame start.
- Sample latency: accepted sample drives the modulator from the next frame start, at most OSR×DIV `clk` cycles after acceptance.
- Throughput: one sample per OSR×DIV `clk` cycles.
  - `s_ready` drops the cycle after accept.
  - `s_ready` rises the cycle after the consuming frame start.
- `mdata_out` is valid DIV/2 `clk` cycles before each `mclk_out` falling edge (filter integrates on negedge).
- Reset asserted mid-frame: all state returns to reset values immediately, and any held sample is discarded.
- The frame then restarts at the first edge after release.

## Structure
- Package `sd_pkg` holds:
  - `SD_MID` = 0x8000.
  - `SD_CLAMP_LO` = 0x1000, `SD_CLAMP_HI` = 0xF000.
  - `SD_FB_MAG` = 32768.
  - The saturating-add width rule.
- Sub-module `sd_clk_gen` owns ph, bc, `mclk_out`, and the step/frame-start strobes.
- The top level holds the hold register, handshake, clamp and integrators.

## Test plan
- Reset, no input, 4 frames → `mclk_out` period DIV `clk`; `word_tick` every 1024 `clk`; ones per frame 128±2; `underrun` never pulses.
- Single sample 0xC000 accepted → from next frame start, ones per frame 192±2; `s_ready` low until that frame start.
- Inputs 0x0000 then 0xFFFF → clamped; ones per frame 16±2 then 240±2; integrators never saturate.
- Back-to-back `s_valid` held high with samples 0x4000, 0x8000, 0xA000 → exactly one accept per frame; densities 64, 128, 160 (±2) in order.
- Stop supplying after 0x6000 → `underrun` pulses once per frame start; 0x6000 density (96±2) repeats.
- Loopback: `mclk_out`/`mdata_out`/`word_tick` drive the sinc3 filter (OSR 256); a constant 0x9000 reads back within ±8 LSB after 3 frames.
- Reset mid-frame with hold full → outputs return to reset values asynchronously; after release, density 128±2 and `s_ready`=1.
